// File: rtl/uart_hex_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_hex_tx                                                   |
// | Purpose  : UART 8N1 transmitter. Converts a 4-bit value into one ASCII   |
// |            hex character ('0'..'9', 'A'..'F') and serialises it on the   |
// |            board TXD pin. One-byte capture register, no FIFO.            |
// | Ports    : FPGA_CLK  in  1  system clock, rising edge                     |
// |            RESET_BUT in  1  asynchronous active-low reset                 |
// |            data_in   in  4  value to send, sampled on request accept      |
// |            send      in  1  one-cycle request pulse                       |
// |            UART_TXD  out 1  serial line, idle high                        |
// |            busy      out 1  high while a frame sequence is in progress    |
// |            done      out 1  one-cycle pulse after the final stop bit      |
// | Config   : `define UART_HEX_TX_CRLF_EN to follow every hex character     |
// |            with CR (8'h0D) and LF (8'h0A) in one busy window.            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module uart_hex_tx #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic       FPGA_CLK,
  input  logic       RESET_BUT,
  input  logic [3:0] data_in,
  input  logic       send,
  output logic       UART_TXD,
  output logic       busy,
  output logic       done
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int                  c_BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [c_BAUD_W-1:0] c_BAUD_ONE  = c_BAUD_W'(1);

  localparam logic [1:0] c_S_IDLE  = 2'd0;
  localparam logic [1:0] c_S_START = 2'd1;
  localparam logic [1:0] c_S_DATA  = 2'd2;
  localparam logic [1:0] c_S_STOP  = 2'd3;

`ifdef UART_HEX_TX_CRLF_EN
  localparam logic [7:0] c_ASCII_CR   = 8'h0D;
  localparam logic [7:0] c_ASCII_LF   = 8'h0A;
  localparam logic [1:0] c_FRAME_LAST = 2'd2;
`endif

  // --------------------------------------------------------------------------
  // Registers and next-state wires
  // --------------------------------------------------------------------------
  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [c_BAUD_W-1:0] r_baud_cnt;
  logic [c_BAUD_W-1:0] w_baud_nxt;
  logic [2:0]          r_bit_idx;
  logic [2:0]          w_bit_idx_nxt;
  logic [7:0]          r_shift;
  logic [7:0]          w_shift_nxt;
  logic                r_txd;
  logic                w_txd_nxt;
  logic                r_busy;
  logic                w_busy_nxt;
  logic                r_done;
  logic                w_done_nxt;
`ifdef UART_HEX_TX_CRLF_EN
  logic [1:0]          r_frame_idx;
  logic [1:0]          w_frame_nxt;
`endif

  logic                w_bit_end;
  logic                w_last_frame;
  logic [7:0]          w_hex;

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  // Final cycle of the current bit period.
  assign w_bit_end = (r_baud_cnt == c_BAUD_LAST);

  // 0..9 map onto '0'..'9'; 10..15 map onto 'A'..'F' (8'h37 + 10 = 8'h41).
  assign w_hex = (data_in < 4'd10) ? (8'h30 + {4'h0, data_in})
                                   : (8'h37 + {4'h0, data_in});

`ifdef UART_HEX_TX_CRLF_EN
  assign w_last_frame = (r_frame_idx == c_FRAME_LAST);
`else
  assign w_last_frame = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge FPGA_CLK or negedge RESET_BUT) begin
    if (!RESET_BUT) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  // In IDLE busy is always low, so send alone is an accepted request.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (send) w_state_nxt = c_S_START;
      end
      c_S_START: begin
        if (w_bit_end) w_state_nxt = c_S_DATA;
      end
      c_S_DATA: begin
        if (w_bit_end && (r_bit_idx == 3'd7)) w_state_nxt = c_S_STOP;
      end
      c_S_STOP: begin
        if (w_bit_end) w_state_nxt = w_last_frame ? c_S_IDLE : c_S_START;
      end
      default: w_state_nxt = c_S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output / datapath logic
  // --------------------------------------------------------------------------
  // All outputs are computed one edge ahead and registered, so the line
  // value for a bit is set on the same edge that enters that bit.
  always_comb begin
    w_baud_nxt    = w_bit_end ? '0 : (r_baud_cnt + c_BAUD_ONE);
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_txd_nxt     = r_txd;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
`ifdef UART_HEX_TX_CRLF_EN
    w_frame_nxt   = r_frame_idx;
`endif
    case (r_state)
      c_S_IDLE: begin
        w_baud_nxt = '0;
        w_txd_nxt  = 1'b1;
        w_busy_nxt = 1'b0;
        if (send) begin
          w_shift_nxt   = w_hex;
          w_bit_idx_nxt = 3'd0;
          w_txd_nxt     = 1'b0;
          w_busy_nxt    = 1'b1;
`ifdef UART_HEX_TX_CRLF_EN
          w_frame_nxt   = 2'd0;
`endif
        end
      end
      c_S_START: begin
        if (w_bit_end) begin
          w_bit_idx_nxt = 3'd0;
          w_txd_nxt     = r_shift[0];
        end
      end
      c_S_DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == 3'd7) begin
            w_txd_nxt = 1'b1;
          end else begin
            // LSB first: the next bit to drive sits at position 1 before the shift.
            w_shift_nxt   = {1'b0, r_shift[7:1]};
            w_txd_nxt     = r_shift[1];
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      c_S_STOP: begin
        if (w_bit_end) begin
          if (w_last_frame) begin
            w_txd_nxt  = 1'b1;
            w_busy_nxt = 1'b0;
            w_done_nxt = 1'b1;
          end else begin
`ifdef UART_HEX_TX_CRLF_EN
            // Chain straight into the next start bit with no idle cycle.
            w_shift_nxt   = (r_frame_idx == 2'd0) ? c_ASCII_CR : c_ASCII_LF;
            w_frame_nxt   = r_frame_idx + 2'd1;
`endif
            w_bit_idx_nxt = 3'd0;
            w_txd_nxt     = 1'b0;
          end
        end
      end
      default: begin
        w_baud_nxt = '0;
        w_txd_nxt  = 1'b1;
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge FPGA_CLK or negedge RESET_BUT) begin
    if (!RESET_BUT) begin
      r_baud_cnt  <= '0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'h00;
      r_txd       <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef UART_HEX_TX_CRLF_EN
      r_frame_idx <= 2'd0;
`endif
    end else begin
      r_baud_cnt  <= w_baud_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_txd       <= w_txd_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
`ifdef UART_HEX_TX_CRLF_EN
      r_frame_idx <= w_frame_nxt;
`endif
    end
  end

  assign UART_TXD = r_txd;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_hex_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_hex_tx                                                |
// | Purpose  : Self-checking bench for uart_hex_tx. Stimulus pushes expected |
// |            bytes into a queue; an independent line monitor decodes each  |
// |            frame from UART_TXD and compares it against the queue head.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_uart_hex_tx;

  localparam int CPB   = 434;            // 50_000_000 / 115200, truncated
  localparam int LIMIT = 40 * CPB;

  logic       FPGA_CLK  = 1'b0;
  logic       RESET_BUT = 1'b0;
  logic [3:0] data_in   = 4'h0;
  logic       send      = 1'b0;
  logic       UART_TXD;
  logic       busy;
  logic       done;

  uart_hex_tx dut (
    .FPGA_CLK  (FPGA_CLK),
    .RESET_BUT (RESET_BUT),
    .data_in   (data_in),
    .send      (send),
    .UART_TXD  (UART_TXD),
    .busy      (busy),
    .done      (done)
  );

  always #10 FPGA_CLK = ~FPGA_CLK;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // Drive a one-cycle request starting at a falling edge, then scramble
  // data_in so a late change would corrupt the frame if it leaked in.
  task automatic pulse_send(input logic [3:0] v);
    data_in = v;
    send    = 1'b1;
    @(negedge FPGA_CLK);
    send    = 1'b0;
    data_in = ~v;
  endtask

  // Count falling edges with busy high; returns cycles and done pulses seen,
  // including the done on the first cycle busy is low.
  task automatic wait_busy(output int cyc, output int dn);
    cyc = 0;
    dn  = 0;
    while (busy === 1'b1 && cyc < LIMIT) begin
      if (done === 1'b1) dn++;
      cyc++;
      @(negedge FPGA_CLK);
    end
    if (busy !== 1'b0) begin
      n_vec++;
      n_err++;
      $display("FAIL busy_timeout: busy still %b after %0d cycles", busy, cyc);
    end
    if (done === 1'b1) dn++;
  endtask

  // --------------------------------------------------------------------------
  // Line monitor / scoreboard
  // --------------------------------------------------------------------------
  logic       m_prev = 1'b1;
  logic       m_bad;
  logic       m_abort;
  logic [9:0] m_bits;
  logic [7:0] m_exp;

  initial begin : p_monitor
    forever begin
      @(negedge FPGA_CLK);
      if (RESET_BUT === 1'b1 && m_prev === 1'b1 && UART_TXD === 1'b0) begin
        m_bad   = 1'b0;
        m_abort = 1'b0;
        m_bits  = '0;
        for (int b = 0; b < 10; b++) begin
          for (int c = 0; c < CPB; c++) begin
            if (b != 0 || c != 0) @(negedge FPGA_CLK);
            if (RESET_BUT !== 1'b1) m_abort = 1'b1;
            if (c == 0) m_bits[b] = UART_TXD;
            else if (UART_TXD !== m_bits[b]) m_bad = 1'b1;
            if (m_abort) break;
          end
          if (m_abort) break;
        end
        if (!m_abort) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL frame_unexpected: got byte 0x%02h, want no frame", m_bits[8:1]);
          end else begin
            m_exp = exp_q.pop_front();
            // {stable, stop, data, start}
            check("frame_byte", 32'({m_bad, m_bits}), 32'({1'b0, 1'b1, m_exp, 1'b0}));
          end
        end
      end
      m_prev = UART_TXD;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  int   cyc;
  int   dn;
  logic bad;

  initial begin : p_stim
    repeat (3) @(negedge FPGA_CLK);
    check("reset_txd",  32'(UART_TXD), 32'd1);
    check("reset_busy", 32'(busy),     32'd0);
    check("reset_done", 32'(done),     32'd0);
    #2 RESET_BUT = 1'b1;

    // Idle line held with no request.
    bad = 1'b0;
    repeat (10000) begin
      @(negedge FPGA_CLK);
      if (UART_TXD !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
    end
    check("idle_10000", 32'(bad), 32'd0);

    // 'A' -> 8'h41
    exp_q.push_back(8'h41);
    pulse_send(4'hA);
    check("A_latency", 32'({busy, UART_TXD}), 32'b10);
    wait_busy(cyc, dn);
    check("A_busy_len", 32'(cyc), 32'd4340);
    check("A_done_end", 32'(done), 32'd1);
    check("A_done_cnt", 32'(dn), 32'd1);
    @(negedge FPGA_CLK);
    check("A_done_width", 32'(done), 32'd0);

    // '7' with an ignored request for '3' at cycle 1000.
    exp_q.push_back(8'h37);
    pulse_send(4'h7);
    repeat (998) @(negedge FPGA_CLK);
    pulse_send(4'h3);
    wait_busy(cyc, dn);
    check("B_busy_rest", 32'(cyc), 32'd3341);
    check("B_done_cnt", 32'(dn), 32'd1);
    bad = 1'b0;
    repeat (20) begin
      @(negedge FPGA_CLK);
      if (UART_TXD !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    check("B_no_second", 32'(bad), 32'd0);

    // '0' then 'F' with the second request on the done cycle.
    exp_q.push_back(8'h30);
    pulse_send(4'h0);
    wait_busy(cyc, dn);
    check("C0_busy_len", 32'(cyc), 32'd4340);
    check("C0_done_cnt", 32'(dn), 32'd1);
    exp_q.push_back(8'h46);
    pulse_send(4'hF);
    check("C_no_gap", 32'({busy, UART_TXD}), 32'b10);
    wait_busy(cyc, dn);
    check("CF_busy_len", 32'(cyc), 32'd4340);
    check("CF_done_cnt", 32'(dn), 32'd1);

    // Reset at cycle 2000 of a '9' frame, then a clean 'C' frame.
    exp_q.push_back(8'h39);
    pulse_send(4'h9);
    repeat (1999) @(negedge FPGA_CLK);
    #3 RESET_BUT = 1'b0;
    #1;
    check("R_async_line", 32'({busy, UART_TXD}), 32'b01);
    exp_q.delete();
    repeat (3) @(negedge FPGA_CLK);
    check("R_held_done", 32'(done), 32'd0);
    #2 RESET_BUT = 1'b1;
    repeat (5) @(negedge FPGA_CLK);
    exp_q.push_back(8'h43);
    pulse_send(4'hC);
    check("R_latency", 32'({busy, UART_TXD}), 32'b10);
    wait_busy(cyc, dn);
    check("R_busy_len", 32'(cyc), 32'd4340);
    check("R_done_cnt", 32'(dn), 32'd1);

    // '5', optionally followed by CR LF in one busy window.
`ifdef UART_HEX_TX_CRLF_EN
    exp_q.push_back(8'h35);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    pulse_send(4'h5);
    wait_busy(cyc, dn);
    check("E_busy_len", 32'(cyc), 32'd13020);
`else
    exp_q.push_back(8'h35);
    pulse_send(4'h5);
    wait_busy(cyc, dn);
    check("E_busy_len", 32'(cyc), 32'd4340);
`endif
    check("E_done_cnt", 32'(dn), 32'd1);

    repeat (20) @(negedge FPGA_CLK);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : p_watchdog
    #(90000 * 20);
    $display("FAIL watchdog: simulation exceeded 90000 cycles, want completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
